// File: rtl/timer_dev_if.sv
// timer_dev_if: CPU data-bus slave port of the timer (addr/we/din in, dout/irq out)
interface timer_dev_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;
  modport master (output addr, we, din, input dout, irq);
  modport slave (input addr, we, din, output dout, irq);
endinterface

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped 32-bit count-down timer with one-shot/auto-reload modes and irq
// Ports: clk, reset (sync, active-high); bus.addr[3:2] selects CTRL/PRESET/COUNT/reserved,
// bus.we/bus.din write, bus.dout combinational read data, bus.irq = IM & irq_flag.
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  timer_dev_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;
  state_t      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d, count_q, count_d;
  logic        flag_q, flag_d;
  logic        wr_ctrl, wr_preset;
  logic        unused_addr;
  assign unused_addr = ^{bus.addr[31:4], bus.addr[1:0]};
  assign wr_ctrl   = bus.we && bus.addr[3:2] == 2'b00;
  assign wr_preset = bus.we && bus.addr[3:2] == 2'b01;
  assign bus.dout  = bus.addr[3:2] == 2'b00 ? {28'b0, ctrl_q} :
                     bus.addr[3:2] == 2'b01 ? preset_q :
                     bus.addr[3:2] == 2'b10 ? count_q : 32'b0;
  assign bus.irq   = ctrl_q[3] & flag_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
    end
  end
  // The FSM looks only at the pre-edge CTRL; a same-cycle CPU write wins over the INT En clear.
  always_comb begin
    state_d  = state_q;
    ctrl_d   = wr_ctrl ? bus.din[3:0] : ctrl_q;
    preset_d = wr_preset ? bus.din : preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
    case (state_q)
      IDLE: state_d = ctrl_q[0] ? LOAD : IDLE;
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!ctrl_q[0]) state_d = IDLE;
        else if (count_q > 32'd1) count_d = count_q - 32'd1;
        else begin
          count_d = '0;
          flag_d  = 1'b1;
          state_d = INT;
        end
      end
      default: begin
        if (ctrl_q[2:1] == 2'b01) begin
          state_d = LOAD;
          flag_d  = 1'b0;
        end else begin
          state_d = IDLE;
          if (!wr_ctrl) ctrl_d[0] = 1'b0;
        end
      end
    endcase
    if (wr_ctrl || wr_preset) flag_d = 1'b0;
  end
endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped 32-bit count-down timer on the CPU data bus, alongside the data memory. It consumes the store path (ALU-computed address, `we` from MemWrite, rt data as `din`) and returns read data for the MemToReg path. It raises `irq` when the count expires. It supports one-shot and auto-reload modes, giving the core a deterministic time base for interrupt work.

## Interface
- Parameters: none (all registers fixed at 32 bits).
- `clk`  in  1  rising-edge clock, shared with the CPU.
- `reset`  in  1  synchronous, active-high; sampled on the `clk` rising edge.
- `addr`  in  32  byte address from the ALU result. Only `addr[3:2]` is decoded; the bus decoder handles chip select.
- `we`  in  1  write strobe (MemWrite gated by the timer's address decode).
- `din`  in  32  write data.
- `dout`  out  32  combinational read data for `addr[3:2]`.
- `irq`  out  1  interrupt request, registered; equals `IM & irq_flag`.

## Operation
- Register map (`addr[3:2]`):
  - 00 = CTRL
  - 01 = PRESET
  - 10 = COUNT
  - 11 = reserved; reads 0, writes ignored.
- CTRL:
  - bit0 `En`; bits[2:1] `Mode`; bit3 `IM`.
  - bits[31:4] read 0 and writes to them are dropped.
  - Mode 00 = one-shot; 01 = auto-reload; 10 and 11 behave as 00.
- PRESET: fully read/write.
- COUNT: read-only; writes are ignored.
- Reset: CTRL=0, PRESET=0, COUNT=0, irq_flag=0, state=IDLE, `irq`=0.
- FSM states are IDLE, LOAD, CNT, INT.
  - IDLE: `En`=1 → LOAD; otherwise stay. COUNT holds its value.
  - LOAD: COUNT←PRESET; → CNT.
  - CNT:
    - `En`=0 → IDLE; COUNT freezes.
    - COUNT>1 → COUNT−1.
    - COUNT=1 → COUNT←0, irq_flag←1, → INT.
    - COUNT=0 (PRESET was 0) → irq_flag←1, → INT.
  - INT, mode 00: CTRL.`En`←0, → IDLE. irq_flag stays set.
  - INT, mode 01: → LOAD; irq_flag←0 on leaving INT.
- irq_flag clear: any CPU write to CTRL or PRESET clears it, regardless of state.
- Same-cycle conflicts:
  - A CPU write to CTRL overrides the INT-state `En` clear. The written value is what is stored.
  - The FSM evaluates the CTRL value in effect before the edge. A write's effect on state is seen from the next edge.
- A PRESET write during CNT does not alter the running COUNT. It takes effect at the next LOAD.
- COUNT never wraps below 0.

## Timing
- Writes are captured on the rising edge at which `we`=1. Reads are combinational, with zero latency.
- CTRL write `En`=1 captured at edge t (state IDLE), with PRESET=N≥1:
  - LOAD at t+1.
  - CNT with COUNT=N at t+2.
  - COUNT=N−k at t+2+k.
  - COUNT=0, state INT, `irq` high (if IM) at t+2+N.
- PRESET=0: INT and `irq` at t+3.
- One-shot: IDLE and CTRL.`En`=0 at t+3+N. `irq` stays high until CTRL or PRESET is written. The clear is seen one edge after the write edge.
- Auto-reload:
  - `irq` is high for exactly one cycle per expiry.
  - Expiries occur every N+2 cycles (INT → LOAD → CNT overhead).
- Clearing `En` while in CNT at edge s gives IDLE at s+1, with COUNT frozen at its s+1 value.
- Reset asserted mid-count: on the next edge, all state returns to reset values and `irq` drops, regardless of other inputs.

## Test plan
- After reset, read CTRL/PRESET/COUNT/addr 11 → all 0, `irq`=0. Write 0xFFFFFFFF to COUNT and to addr 11 → both still read 0. Write 0xFFFFFFFF to CTRL → reads 0x0000000F.
- PRESET=5, CTRL=0x9 (one-shot, IM) at edge t → COUNT reads 5,4,3,2,1,0 at t+2..t+7. `irq`=1 from t+7. CTRL reads 0x8 from t+8. `irq` holds until CTRL is rewritten, then drops the edge after.
- PRESET=3, CTRL=0xB (auto-reload, IM) → `irq` single-cycle pulses at t+5, t+10, t+15. A PRESET write of 6 mid-count leaves the current period unchanged; the next period is 8 cycles.
- PRESET=0, CTRL=0x9 → `irq` at t+3. CTRL=0x1 (IM=0) with PRESET=2 → no `irq`, state still reaches IDLE and CTRL reads 0x0 at t+5.
- Edge cases:
  - Start with PRESET=10; write CTRL=0x0 when COUNT=7 → COUNT freezes at 6.
  - Re-enable → reloads 10.
  - A CTRL write in the INT cycle with `En`=1 → `En` remains 1 and the timer restarts.
  - Assert `reset` while COUNT=4 → all registers 0 next edge.
